soc_lint_xbar: RTL and testbench
================================

# soc_lint_xbar

Parametrised request/grant crossbar joining NB_MASTER core/debug/DMA request ports to NB_SLAVE memory and peripheral targets through a configurable address map. It is the next-generation successor to the fixed three-by-three SoC interconnect: master and slave counts, address map and response-tracking depth are parameters. It adds per-slave arbitration, in-order response routing and a decode-error responder. It sits at SoC top level between the core region and the instruction RAM, data RAM and peripheral subsystem.

## Interface
- NB_MASTER, 3, number of initiator ports (1..8)
- NB_SLAVE, 3, number of target ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- RSP_DEPTH, 2, per-slave response-routing FIFO depth (>=1)
- START_ADDR, {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000}, packed NB_SLAVE x ADDR_WIDTH region bases, slave 0 in the LSBs
- END_ADDR, {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF}, packed inclusive region ends
- ERR_RDATA, 32'hBADA_CCE5, read data returned on a decode error
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req_i  in  NB_MASTER  per-master request
- m_gnt_o  out  NB_MASTER  per-master grant
- m_addr_i  in  NB_MASTER*ADDR_WIDTH  addresses
- m_we_i  in  NB_MASTER  write enable
- m_be_i  in  NB_MASTER*DATA_WIDTH/8  byte enables
- m_wdata_i  in  NB_MASTER*DATA_WIDTH  write data
- m_rvalid_o  out  NB_MASTER  response valid
- m_rdata_o  out  NB_MASTER*DATA_WIDTH  response data
- m_err_o  out  NB_MASTER  decode error, qualified by m_rvalid_o
- s_req_o  out  NB_SLAVE  per-slave request
- s_gnt_i  in  NB_SLAVE  slave grant
- s_addr_o / s_we_o / s_be_o / s_wdata_o  out  NB_SLAVE x field width  forwarded request fields
- s_rvalid_i  in  NB_SLAVE  slave response valid
- s_rdata_i  in  NB_SLAVE*DATA_WIDTH  slave response data

## Operation
- Decode: the master targets slave i if START_ADDR[i] <= addr <= END_ADDR[i], unsigned compare. On overlapping regions, the lowest index wins. No match targets the internal error slave.
- Eligibility: m_req_i high, master pending flag clear, and the target's FIFO not full, or full with a pop in the same cycle.
- Per-slave arbiter: selects one eligible master. s_req_o[i] and the request fields of the winner are driven combinationally. m_gnt_o[winner] = s_gnt_i[i] in the same cycle.
- On a handshake, the master index is pushed into slave i's FIFO, the master's pending flag is set, and the arbiter pointer moves to winner+1, modulo NB_MASTER.
- Error slave: grants an eligible master immediately, with lowest-index priority. Next cycle it returns m_rvalid_o=1, m_err_o=1, m_rdata_o=ERR_RDATA.
- Response: s_rvalid_i[i] pops FIFO head h. On the next cycle, m_rvalid_o[h]=1 and m_rdata_o[h] = the captured s_rdata_i. The response also clears pending[h].
- Each master has at most one outstanding transaction, so no two responses ever collide on one master.
- A master whose pending flag is set sees m_gnt_o=0 until the cycle after its m_rvalid_o.
- s_rvalid_i with an empty FIFO is ignored (protocol violation; the bench flags it).
- Masters hold req and all fields stable until gnt. A dropped req before gnt is permitted.

## Timing
- Reset values: m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o, s_req_o = 0. FIFOs are empty, pending flags are 0, arbiter pointers are 0.
- s_req_o and m_gnt_o are forced 0 while rst_n is low.
- Grant latency: combinational from s_gnt_i, 0 cycles. Response latency: s_rvalid_i at cycle t gives m_rvalid_o at t+1. Error response: grant at t gives rvalid at t+1.
- Minimum back-to-back issue per master: grant, response, then new grant one cycle after m_rvalid_o.
- Reset mid-transaction flushes FIFOs and pending flags. Later slave responses are dropped per the empty-FIFO rule.
- FIFO entry width is max(1, $clog2(NB_MASTER)). Pointer wrap is modulo RSP_DEPTH.

## Configuration
- SOC_XBAR_RR_ARB_EN defined: round-robin per slave, with the pointer updated on each handshake as above.
- Not defined: fixed priority, lowest master index wins. The pointer logic is removed.

## Test plan
- Master 0 reads 0x0000_0100; slave 0 grants the same cycle and returns rdata 0x1234_5678 two cycles later. Required: m_gnt_o[0] the same cycle, m_rvalid_o[0] one cycle after s_rvalid_i[0], rdata 0x1234_5678.
- Masters 0, 1 and 2 continuously request 0x0010_0000 with s_gnt_i[1] held high, macro defined. Required: grant order 0,1,2,0,... Without the macro: master 0 is granted each time it becomes eligible.
- Master 1 requests 0x2000_0000 (unmapped). Required: gnt the same cycle; next cycle m_rvalid_o[1]=1, m_err_o[1]=1, rdata 0xBADA_CCE5; no s_req_o asserted.
- RSP_DEPTH=2, slave 2 grants but withholds rvalid; masters 0, 1 and 2 target 0x1A10_0000. Required: masters 0 and 1 are granted, master 2 is blocked until the first s_rvalid_i[2]. Responses route in order 0 then 1.
- Master 0 is pending on slave 1 and re-asserts req to slave 0. Required: no gnt until the cycle after m_rvalid_o[0].
- rst_n pulsed low with two transactions in flight. Required: all outputs 0 immediately. A post-reset s_rvalid_i produces no m_rvalid_o.

Source files
------------

// File: rtl/soc_lint_xbar.sv
// Request/grant crossbar: NB_MASTER initiators to NB_SLAVE targets plus an internal decode-error slave.
// Define SOC_XBAR_RR_ARB_EN for round-robin per-slave arbitration; otherwise lowest master index wins.
module soc_lint_xbar #(
    parameter int unsigned NB_MASTER  = 3,
    parameter int unsigned NB_SLAVE   = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 2,
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] START_ADDR =
        {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NB_SLAVE*ADDR_WIDTH-1:0] END_ADDR =
        {32'h1A11_FFFF, 32'h0FFF_FFFF, 32'h000F_FFFF},
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADA_CCE5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NB_MASTER-1:0]             m_req_i,
    output logic [NB_MASTER-1:0]             m_gnt_o,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [NB_MASTER-1:0]             m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]  m_wdata_i,
    output logic [NB_MASTER-1:0]             m_rvalid_o,
    output logic [NB_MASTER*DATA_WIDTH-1:0]  m_rdata_o,
    output logic [NB_MASTER-1:0]             m_err_o,
    output logic [NB_SLAVE-1:0]              s_req_o,
    input  logic [NB_SLAVE-1:0]              s_gnt_i,
    output logic [NB_SLAVE*ADDR_WIDTH-1:0]   s_addr_o,
    output logic [NB_SLAVE-1:0]              s_we_o,
    output logic [NB_SLAVE*DATA_WIDTH/8-1:0] s_be_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]   s_wdata_o,
    input  logic [NB_SLAVE-1:0]              s_rvalid_i,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]   s_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int unsigned TGT_W    = $clog2(NB_SLAVE + 1);
    localparam int unsigned PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NB_SLAVE);

    logic [TGT_W-1:0]     tgt     [NB_MASTER];
    logic [NB_MASTER-1:0] elig;
    logic [NB_MASTER-1:0] err_gnt;
    logic [NB_MASTER-1:0] slv_gnt;
    logic [NB_SLAVE-1:0]  win_valid;
    logic [IDX_W-1:0]     win_idx [NB_SLAVE];
    logic [IDX_W-1:0]     head    [NB_SLAVE];
    logic [NB_SLAVE-1:0]  push;
    logic [NB_SLAVE-1:0]  pop;

    logic [IDX_W-1:0]     fifo_q   [NB_SLAVE][RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NB_SLAVE];
    logic [PTR_W-1:0]     rd_ptr_q [NB_SLAVE];
    logic [CNT_W-1:0]     cnt_q    [NB_SLAVE];
    logic [NB_MASTER-1:0] pending_q;
    logic [NB_MASTER-1:0] rvalid_q;
    logic [NB_MASTER-1:0] err_q;
    logic [NB_MASTER*DATA_WIDTH-1:0] rdata_q;
`ifdef SOC_XBAR_RR_ARB_EN
    logic [IDX_W-1:0]     rr_ptr_q [NB_SLAVE];
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Descending scan so the lowest matching region index is the last (winning) assignment.
    always_comb begin
        for (int m = 0; m < int'(NB_MASTER); m++) begin
            tgt[m] = ERR_TGT;
            for (int s = int'(NB_SLAVE) - 1; s >= 0; s--) begin
                if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= START_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH] &&
                    m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= END_ADDR[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    tgt[m] = TGT_W'(s);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            head[s] = fifo_q[s][rd_ptr_q[s]];
            pop[s]  = s_rvalid_i[s] && (cnt_q[s] != '0);
        end
    end

    // A full response FIFO still accepts a push when it is popped in the same cycle.
    always_comb begin
        for (int m = 0; m < int'(NB_MASTER); m++) begin
            elig[m] = m_req_i[m] && !pending_q[m];
            for (int s = 0; s < int'(NB_SLAVE); s++) begin
                if (tgt[m] == TGT_W'(s) && cnt_q[s] == CNT_W'(RSP_DEPTH) && !pop[s]) begin
                    elig[m] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            win_valid[s] = 1'b0;
            win_idx[s]   = '0;
            for (int k = int'(NB_MASTER) - 1; k >= 0; k--) begin
                int unsigned cand;
`ifdef SOC_XBAR_RR_ARB_EN
                cand = (32'(rr_ptr_q[s]) + 32'(k)) % NB_MASTER;
`else
                cand = 32'(k);
`endif
                if (elig[cand] && tgt[cand] == TGT_W'(s)) begin
                    win_valid[s] = 1'b1;
                    win_idx[s]   = IDX_W'(cand);
                end
            end
        end
    end

    always_comb begin
        err_gnt = '0;
        for (int m = int'(NB_MASTER) - 1; m >= 0; m--) begin
            if (elig[m] && tgt[m] == ERR_TGT) begin
                err_gnt = NB_MASTER'(1) << m;
            end
        end
    end

    always_comb begin
        slv_gnt = '0;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            push[s]    = win_valid[s] && s_gnt_i[s];
            s_req_o[s] = win_valid[s] && rst_n;
            s_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH] = m_addr_i[win_idx[s]*ADDR_WIDTH +: ADDR_WIDTH];
            s_we_o[s]                            = m_we_i[win_idx[s]];
            s_be_o[s*BE_WIDTH +: BE_WIDTH]       = m_be_i[win_idx[s]*BE_WIDTH +: BE_WIDTH];
            s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[win_idx[s]*DATA_WIDTH +: DATA_WIDTH];
            for (int m = 0; m < int'(NB_MASTER); m++) begin
                if (push[s] && win_idx[s] == IDX_W'(m)) begin
                    slv_gnt[m] = 1'b1;
                end
            end
        end
    end

    assign m_gnt_o    = (slv_gnt | err_gnt) & {NB_MASTER{rst_n}};
    assign m_rvalid_o = rvalid_q;
    assign m_err_o    = err_q;
    assign m_rdata_o  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(NB_SLAVE); s++) begin
                for (int d = 0; d < int'(RSP_DEPTH); d++) begin
                    fifo_q[s][d] <= '0;
                end
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
`ifdef SOC_XBAR_RR_ARB_EN
                rr_ptr_q[s] <= '0;
`endif
            end
            pending_q <= '0;
            rvalid_q  <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
        end else begin
            for (int s = 0; s < int'(NB_SLAVE); s++) begin
                if (push[s]) begin
                    fifo_q[s][wr_ptr_q[s]] <= win_idx[s];
                    wr_ptr_q[s]            <= ptr_inc(wr_ptr_q[s]);
`ifdef SOC_XBAR_RR_ARB_EN
                    rr_ptr_q[s] <= (win_idx[s] == IDX_W'(NB_MASTER - 1)) ? '0
                                                                        : win_idx[s] + IDX_W'(1);
`endif
                end
                if (pop[s]) begin
                    rd_ptr_q[s] <= ptr_inc(rd_ptr_q[s]);
                end
                cnt_q[s] <= cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
            // Pending stays set through the rvalid cycle, so re-grant comes one cycle later.
            pending_q <= (pending_q & ~rvalid_q) | slv_gnt | err_gnt;
            rvalid_q  <= err_gnt;
            err_q     <= err_gnt;
            for (int m = 0; m < int'(NB_MASTER); m++) begin
                if (err_gnt[m]) begin
                    rdata_q[m*DATA_WIDTH +: DATA_WIDTH] <= ERR_RDATA;
                end
            end
            for (int s = 0; s < int'(NB_SLAVE); s++) begin
                if (pop[s]) begin
                    rvalid_q[head[s]] <= 1'b1;
                    rdata_q[head[s]*DATA_WIDTH +: DATA_WIDTH] <= s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_lint_xbar.sv
// Directed self-checking bench for soc_lint_xbar (3x3, default address map, RSP_DEPTH=2).
module tb_soc_lint_xbar;

    localparam int NM = 3;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

`ifdef SOC_XBAR_RR_ARB_EN
    localparam logic [2:0] T2B_WIN = 3'b010;
`else
    localparam logic [2:0] T2B_WIN = 3'b001;
`endif

    logic              clk;
    logic              rst_n;
    logic [NM-1:0]     m_req_i;
    logic [NM-1:0]     m_gnt_o;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM-1:0]     m_we_i;
    logic [NM*BW-1:0]  m_be_i;
    logic [NM*DW-1:0]  m_wdata_i;
    logic [NM-1:0]     m_rvalid_o;
    logic [NM*DW-1:0]  m_rdata_o;
    logic [NM-1:0]     m_err_o;
    logic [NS-1:0]     s_req_o;
    logic [NS-1:0]     s_gnt_i;
    logic [NS*AW-1:0]  s_addr_o;
    logic [NS-1:0]     s_we_o;
    logic [NS*BW-1:0]  s_be_o;
    logic [NS*DW-1:0]  s_wdata_o;
    logic [NS-1:0]     s_rvalid_i;
    logic [NS*DW-1:0]  s_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    soc_lint_xbar dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m_req_i),
        .m_gnt_o    (m_gnt_o),
        .m_addr_i   (m_addr_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_gnt_i    (s_gnt_i),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_wdata_o  (s_wdata_o),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input logic r, input logic [31:0] a,
                           input logic we = 1'b0, input logic [31:0] wd = 32'h0);
        m_req_i[m]             = r;
        m_addr_i[m*AW +: AW]   = a;
        m_we_i[m]              = we;
        m_be_i[m*BW +: BW]     = 4'hF;
        m_wdata_i[m*DW +: DW]  = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
        s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
        next(); next();
        chk("rst_gnt", m_gnt_o, 0);
        chk("rst_rvalid", m_rvalid_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_rdata", m_rdata_o, 0);
        chk("rst_sreq", s_req_o, 0);
        set_req(0, 1'b1, 32'h0000_0100); s_gnt_i = 3'b111; #1;
        chk("rst_force_sreq", s_req_o, 0);
        chk("rst_force_gnt", m_gnt_o, 0);
        set_req(0, 1'b0, 32'h0); s_gnt_i = '0; rst_n = 1'b1;
        next();

        // Single read on slave 0
        set_req(0, 1'b1, 32'h0000_0100); s_gnt_i = 3'b001; #1;
        chk("t1_sreq", s_req_o, 3'b001);
        chk("t1_gnt", m_gnt_o, 3'b001);
        chk("t1_saddr", s_addr_o[31:0], 32'h0000_0100);
        next(); set_req(0, 1'b0, 32'h0); s_gnt_i = '0; #1;
        chk("t1_rv_idle", m_rvalid_o, 0);
        next(); s_rvalid_i[0] = 1'b1; s_rdata_i[31:0] = 32'h1234_5678; #1;
        chk("t1_rv_early", m_rvalid_o, 0);
        next(); s_rvalid_i = '0; #1;
        chk("t1_rvalid", m_rvalid_o, 3'b001);
        chk("t1_rdata", m_rdata_o[31:0], 32'h1234_5678);
        chk("t1_err", m_err_o, 0);
        next();

        // Unmapped address goes to the error slave
        set_req(1, 1'b1, 32'h2000_0000); #1;
        chk("t3_gnt", m_gnt_o, 3'b010);
        chk("t3_sreq", s_req_o, 0);
        next(); set_req(1, 1'b0, 32'h0); #1;
        chk("t3_rvalid", m_rvalid_o, 3'b010);
        chk("t3_err", m_err_o, 3'b010);
        chk("t3_rdata", m_rdata_o[63:32], 32'hBADA_CCE5);
        next(); #1;
        chk("t3_rv_once", m_rvalid_o, 0);

        // Three masters continuously hitting slave 1, responses every cycle
        for (int m = 0; m < NM; m++) set_req(m, 1'b1, 32'h0010_0000);
        s_gnt_i = 3'b010;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("t2_gnt_c%0d", c), m_gnt_o, 3'b001 << (c % 3));
            if (c >= 2) chk($sformatf("t2_rv_c%0d", c), m_rvalid_o, 3'b001 << ((c - 2) % 3));
            next();
            s_rvalid_i[1] = 1'b1;
        end
        for (int m = 0; m < NM; m++) set_req(m, 1'b0, 32'h0);
        #1;
        chk("t2_rv_c6", m_rvalid_o, 3'b010);
        next(); s_rvalid_i = '0; s_gnt_i = '0; #1;
        chk("t2_rv_c7", m_rvalid_o, 3'b100);
        next();

        // Arbitration policy: after master 0 is served, masters 0 and 1 contend
        set_req(0, 1'b1, 32'h0020_0000); s_gnt_i = 3'b010; #1;
        chk("t2b_first", m_gnt_o, 3'b001);
        next(); set_req(0, 1'b0, 32'h0); s_rvalid_i[1] = 1'b1;
        next(); s_rvalid_i = '0; #1;
        chk("t2b_rv0", m_rvalid_o, 3'b001);
        next();
        set_req(0, 1'b1, 32'h0020_0000); set_req(1, 1'b1, 32'h0020_0004); #1;
        chk("t2b_policy", m_gnt_o, T2B_WIN);
        next(); set_req(0, 1'b0, 32'h0); set_req(1, 1'b0, 32'h0);
        s_gnt_i = '0; s_rvalid_i[1] = 1'b1;
        next(); s_rvalid_i = '0; #1;
        chk("t2b_rv_win", m_rvalid_o, T2B_WIN);
        next();

        // FIFO full on slave 2 blocks master 2 until the first response
        for (int m = 0; m < NM; m++) set_req(m, 1'b1, 32'h1A10_0000);
        s_gnt_i = 3'b100; #1;
        chk("t4_gnt0", m_gnt_o, 3'b001);
        chk("t4_sreq", s_req_o, 3'b100);
        next(); #1;
        chk("t4_gnt1", m_gnt_o, 3'b010);
        next(); #1;
        chk("t4_full_gnt", m_gnt_o, 0);
        chk("t4_full_sreq", s_req_o, 0);
        next(); s_rvalid_i[2] = 1'b1; s_rdata_i[95:64] = 32'hD0D0_0000; #1;
        chk("t4_gnt2", m_gnt_o, 3'b100);
        next();
        for (int m = 0; m < NM; m++) set_req(m, 1'b0, 32'h0);
        s_rdata_i[95:64] = 32'hD1D1_1111; #1;
        chk("t4_rv0", m_rvalid_o, 3'b001);
        chk("t4_rd0", m_rdata_o[31:0], 32'hD0D0_0000);
        next(); s_rdata_i[95:64] = 32'hD2D2_2222; #1;
        chk("t4_rv1", m_rvalid_o, 3'b010);
        chk("t4_rd1", m_rdata_o[63:32], 32'hD1D1_1111);
        next(); s_rvalid_i = '0; s_gnt_i = '0; #1;
        chk("t4_rv2", m_rvalid_o, 3'b100);
        chk("t4_rd2", m_rdata_o[95:64], 32'hD2D2_2222);
        next();

        // Pending master retargets another slave: held off until after its response
        set_req(0, 1'b1, 32'h0010_0000); s_gnt_i = 3'b011; #1;
        chk("t5_gnt_s1", m_gnt_o, 3'b001);
        next(); set_req(0, 1'b1, 32'h0000_0200, 1'b1, 32'hA5A5_5A5A); #1;
        chk("t5_blk_gnt", m_gnt_o, 0);
        chk("t5_blk_sreq", s_req_o, 0);
        next(); s_rvalid_i[1] = 1'b1; #1;
        chk("t5_blk_pop", m_gnt_o, 0);
        next(); s_rvalid_i = '0; #1;
        chk("t5_rv", m_rvalid_o, 3'b001);
        chk("t5_blk_rv", m_gnt_o, 0);
        next(); #1;
        chk("t5_regnt", m_gnt_o, 3'b001);
        chk("t5_swe", s_we_o[0], 1'b1);
        chk("t5_swdata", s_wdata_o[31:0], 32'hA5A5_5A5A);
        next(); set_req(0, 1'b0, 32'h0); s_gnt_i = '0; s_rvalid_i[0] = 1'b1;
        next(); s_rvalid_i = '0; #1;
        chk("t5_rv2", m_rvalid_o, 3'b001);
        next();

        // Reset with transactions in flight
        set_req(0, 1'b1, 32'h0000_0300); set_req(1, 1'b1, 32'h0010_0004);
        s_gnt_i = 3'b011; #1;
        chk("t6_gnt", m_gnt_o, 3'b011);
        next(); set_req(0, 1'b0, 32'h0); set_req(1, 1'b0, 32'h0);
        s_gnt_i = '0; s_rvalid_i[0] = 1'b1; s_rdata_i[31:0] = 32'h600D_0000;
        next(); s_rvalid_i = '0; #1;
        chk("t6_rv_pre", m_rvalid_o, 3'b001);
        rst_n = 1'b0; set_req(2, 1'b1, 32'h0000_0400); s_gnt_i = 3'b001; #1;
        chk("t6_rst_rv", m_rvalid_o, 0);
        chk("t6_rst_rdata", m_rdata_o, 0);
        chk("t6_rst_gnt", m_gnt_o, 0);
        chk("t6_rst_sreq", s_req_o, 0);
        chk("t6_rst_err", m_err_o, 0);
        next(); rst_n = 1'b1; set_req(2, 1'b0, 32'h0); s_gnt_i = '0;
        s_rvalid_i[1] = 1'b1; s_rdata_i[63:32] = 32'hDEAD_BEEF;
        next(); s_rvalid_i = '0; #1;
        chk("t6_drop", m_rvalid_o, 0);
        set_req(1, 1'b1, 32'h0010_0008); s_gnt_i = 3'b010; #1;
        chk("t6_post_gnt", m_gnt_o, 3'b010);
        next(); set_req(1, 1'b0, 32'h0); s_gnt_i = '0; s_rvalid_i[1] = 1'b1;
        next(); s_rvalid_i = '0; #1;
        chk("t6_post_rv", m_rvalid_o, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
